// File: rtl/fb_row_writer.sv
// Tile-row to framebuffer writer: buffers SM tile rows and bursts each as four 64-bit words.
// Optional coordinate bounds check enabled by defining FB_ROW_WRITER_BOUNDS_CHECK_EN.
module fb_row_writer #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_row_valid,
    output logic         o_row_ready,
    input  logic [5:0]   i_current_tile_x,
    input  logic [5:0]   i_current_tile_y,
    input  logic [3:0]   i_tile_row,
    input  logic [255:0] i_sm_color_data,
    input  logic         i_sm_render_done,
    output logic         o_fb_we,
    output logic [16:0]  o_fb_addr,
    output logic [63:0]  o_fb_wdata,
    input  logic         i_fb_ready,
    output logic         o_frame_done,
    output logic         o_busy,
    output logic         o_err_coord
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;

    state_t         state;
    logic [1:0]     beat;
    logic [255:0]   row_data;
    logic           pending;
    logic           row_ready_q;

    logic [5:0]     q_x [FIFO_DEPTH];
    logic [5:0]     q_y [FIFO_DEPTH];
    logic [3:0]     q_r [FIFO_DEPTH];
    logic [255:0]   q_d [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count, count_next;

    logic           push, store, pop, fifo_nempty, flush_go;
    logic [16:0]    line_idx, head_base;

    assign push        = i_row_valid & row_ready_q;
    assign fifo_nempty = (count != '0);
    assign pop         = fifo_nempty &&
                         ((state == IDLE) ||
                          (state == BURST && i_fb_ready && beat == 2'd3));
    assign flush_go    = (state == IDLE) && !fifo_nempty && pending;

`ifdef FB_ROW_WRITER_BOUNDS_CHECK_EN
    logic in_range;
    logic err_q;
    // Out-of-range rows complete the handshake but are never stored.
    assign in_range    = (i_current_tile_x <= 6'd39) && (i_current_tile_y <= 6'd29);
    assign store       = push & in_range;
    assign o_err_coord = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (push && !in_range)
            err_q <= 1'b1;
    end
`else
    assign store       = push;
    assign o_err_coord = 1'b0;
`endif

    always_comb begin
        count_next = count;
        if (store && !pop)
            count_next = count + (AW+1)'(1);
        else if (!store && pop)
            count_next = count - (AW+1)'(1);
    end

    // (y*16 + row)*160 + x*4, with *160 as two shifts, all at 17 bits.
    always_comb begin
        line_idx  = {7'b0, q_y[rd_ptr], 4'b0} + {13'b0, q_r[rd_ptr]};
        head_base = (line_idx << 7) + (line_idx << 5) + {9'b0, q_x[rd_ptr], 2'b0};
    end

    always_ff @(posedge clk) begin
        if (store) begin
            q_x[wr_ptr] <= i_current_tile_x;
            q_y[wr_ptr] <= i_current_tile_y;
            q_r[wr_ptr] <= i_tile_row;
            q_d[wr_ptr] <= i_sm_color_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            beat         <= 2'd0;
            row_data     <= '0;
            pending      <= 1'b0;
            row_ready_q  <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            o_fb_we      <= 1'b0;
            o_fb_addr    <= '0;
            o_fb_wdata   <= '0;
            o_frame_done <= 1'b0;
        end else begin
            count       <= count_next;
            row_ready_q <= (count_next != (AW+1)'(FIFO_DEPTH));
            if (store)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);

            if (flush_go)
                pending <= 1'b0;
            else if (i_sm_render_done)
                pending <= 1'b1;

            o_frame_done <= 1'b0;

            if (pop) begin
                state      <= BURST;
                beat       <= 2'd0;
                o_fb_we    <= 1'b1;
                o_fb_addr  <= head_base;
                o_fb_wdata <= q_d[rd_ptr][63:0];
                row_data   <= q_d[rd_ptr];
            end else begin
                case (state)
                    IDLE: begin
                        if (pending) begin
                            state        <= FLUSH;
                            o_frame_done <= 1'b1;
                        end
                    end
                    BURST: begin
                        if (i_fb_ready) begin
                            if (beat == 2'd3) begin
                                state   <= IDLE;
                                o_fb_we <= 1'b0;
                            end else begin
                                // Row register shifts down so the next word is always at [127:64].
                                beat       <= beat + 2'd1;
                                o_fb_addr  <= o_fb_addr + 17'd1;
                                o_fb_wdata <= row_data[127:64];
                                row_data   <= {64'b0, row_data[255:64]};
                            end
                        end
                    end
                    FLUSH:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign o_row_ready = row_ready_q;
    assign o_busy      = fifo_nempty | (state == BURST);

endmodule

// File: tb/tb_fb_row_writer.sv
// Directed bench for fb_row_writer: latency, addressing, stalls, frame-done and reset abandonment.
// Build with FB_ROW_WRITER_BOUNDS_CHECK_EN defined to exercise the bounds-check variant.
module tb_fb_row_writer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_row_valid;
    logic         o_row_ready;
    logic [5:0]   i_current_tile_x;
    logic [5:0]   i_current_tile_y;
    logic [3:0]   i_tile_row;
    logic [255:0] i_sm_color_data;
    logic         i_sm_render_done;
    logic         o_fb_we;
    logic [16:0]  o_fb_addr;
    logic [63:0]  o_fb_wdata;
    logic         i_fb_ready;
    logic         o_frame_done;
    logic         o_busy;
    logic         o_err_coord;

    fb_row_writer #(.FIFO_DEPTH(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_row_valid      (i_row_valid),
        .o_row_ready      (o_row_ready),
        .i_current_tile_x (i_current_tile_x),
        .i_current_tile_y (i_current_tile_y),
        .i_tile_row       (i_tile_row),
        .i_sm_color_data  (i_sm_color_data),
        .i_sm_render_done (i_sm_render_done),
        .o_fb_we          (o_fb_we),
        .o_fb_addr        (o_fb_addr),
        .o_fb_wdata       (o_fb_wdata),
        .i_fb_ready       (i_fb_ready),
        .o_frame_done     (o_frame_done),
        .o_busy           (o_busy),
        .o_err_coord      (o_err_coord)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [16:0] addr;
        logic [63:0] data;
    } beat_t;

    beat_t beats[$];
    int    dones[$];
    int    cyc = 0;
    int    n_vec = 0;
    int    n_miss = 0;
    logic  tog_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (tog_en) i_fb_ready = ~i_fb_ready;
    end

    // Records accepted beats and done pulses; checks beat stability across stalls.
    logic        prev_stall = 1'b0;
    logic [16:0] prev_addr;
    logic [63:0] prev_data;
    always @(negedge clk) begin
        if (prev_stall && o_fb_we) begin
            check("stall_addr", 64'(o_fb_addr), 64'(prev_addr));
            check("stall_data", o_fb_wdata, prev_data);
        end
        prev_stall = o_fb_we && !i_fb_ready && rst_n;
        prev_addr  = o_fb_addr;
        prev_data  = o_fb_wdata;
        if (o_fb_we && i_fb_ready) beats.push_back('{cyc, o_fb_addr, o_fb_wdata});
        if (o_frame_done) dones.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] pix(input logic [7:0] s, input int j);
        return {s, 8'(j)};
    endfunction

    function automatic logic [255:0] mk_row(input logic [7:0] s);
        logic [255:0] r;
        for (int unsigned j = 0; j < 16; j++) r[16*j +: 16] = pix(s, int'(j));
        return r;
    endfunction

    function automatic logic [63:0] exp_word(input logic [7:0] s, input int b);
        return {pix(s, 4*b+3), pix(s, 4*b+2), pix(s, 4*b+1), pix(s, 4*b)};
    endfunction

    task automatic send_row(input logic [5:0] x, input logic [5:0] y, input logic [3:0] r,
                            input logic [255:0] d);
        int k = 0;
        i_current_tile_x = x;
        i_current_tile_y = y;
        i_tile_row       = r;
        i_sm_color_data  = d;
        i_row_valid      = 1'b1;
        while (!o_row_ready && k < 50) begin
            step(1);
            k++;
        end
        if (k == 50) check("row_ready_wait", 64'(o_row_ready), 64'd1);
        step(1);
        i_row_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (beats.size() < n && k < budget) begin
            step(1);
            k++;
        end
        step(3);
        check("beat_count", 64'(beats.size()), 64'(n));
    endtask

    task automatic check_row(input int idx, input logic [16:0] base, input logic [7:0] s);
        for (int b = 0; b < 4; b++) begin
            if (idx + b < beats.size()) begin
                check("row_addr", 64'(beats[idx+b].addr), 64'(base + 17'(b)));
                check("row_data", beats[idx+b].data, exp_word(s, b));
            end
        end
    endtask

    logic [255:0] d21;
    int           n0;

    initial begin
        rst_n            = 1'b0;
        i_row_valid      = 1'b0;
        i_current_tile_x = '0;
        i_current_tile_y = '0;
        i_tile_row       = '0;
        i_sm_color_data  = '0;
        i_sm_render_done = 1'b0;
        i_fb_ready       = 1'b1;

        // Reset state
        step(3);
        check("rst_ready", 64'(o_row_ready), 64'd0);
        check("rst_we",    64'(o_fb_we),     64'd0);
        check("rst_addr",  64'(o_fb_addr),   64'd0);
        check("rst_wdata", o_fb_wdata,       64'd0);
        check("rst_done",  64'(o_frame_done), 64'd0);
        check("rst_busy",  64'(o_busy),      64'd0);
        check("rst_err",   64'(o_err_coord), 64'd0);
        rst_n = 1'b1;
        step(1);
        check("ready_after_rst", 64'(o_row_ready), 64'd1);

        // Origin row: latency and word ordering
        d21 = {64'h1111_2222_3333_4444, 64'hA5A5_5A5A_0F0F_F0F0,
               64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
        beats.delete();
        n0 = cyc;
        send_row(6'd0, 6'd0, 4'd0, d21);
        wait_beats(4, 12);
        if (beats.size() == 4) begin
            check("lat_c0", 64'(beats[0].cyc), 64'(n0 + 2));
            check("lat_c3", 64'(beats[3].cyc), 64'(n0 + 5));
            check("o_a0", 64'(beats[0].addr), 64'd0);
            check("o_a3", 64'(beats[3].addr), 64'd3);
            check("o_d0", beats[0].data, 64'h0123_4567_89AB_CDEF);
            check("o_d1", beats[1].data, 64'hFEDC_BA98_7654_3210);
            check("o_d2", beats[2].data, 64'hA5A5_5A5A_0F0F_F0F0);
            check("o_d3", beats[3].data, 64'h1111_2222_3333_4444);
        end

        // Last tile on screen
        beats.delete();
        send_row(6'd39, 6'd29, 4'd15, mk_row(8'h22));
        wait_beats(4, 12);
        check_row(0, 17'd76796, 8'h22);

        // Three rows back-to-back with fb_ready toggling
        beats.delete();
        tog_en = 1'b1;
        send_row(6'd1, 6'd0, 4'd0, mk_row(8'h41));
        send_row(6'd2, 6'd1, 4'd3, mk_row(8'h42));
        send_row(6'd5, 6'd2, 4'd7, mk_row(8'h43));
        check("ready_full", 64'(o_row_ready), 64'd0);
        check("busy_full",  64'(o_busy),      64'd1);
        wait_beats(12, 80);
        tog_en = 1'b0;
        i_fb_ready = 1'b1;
        step(3);
        check_row(0, 17'd4,    8'h41);
        check_row(4, 17'd3048, 8'h42);
        check_row(8, 17'd6260, 8'h43);
        check("busy_drained", 64'(o_busy), 64'd0);
        check("done_none", 64'(dones.size()), 64'd0);

        // Frame done after two buffered rows
        beats.delete();
        dones.delete();
        send_row(6'd0, 6'd1, 4'd0, mk_row(8'h51));
        send_row(6'd1, 6'd1, 4'd0, mk_row(8'h52));
        i_sm_render_done = 1'b1;
        step(1);
        i_sm_render_done = 1'b0;
        wait_beats(8, 20);
        step(4);
        check("done_count", 64'(dones.size()), 64'd1);
        if (dones.size() == 1 && beats.size() == 8)
            check("done_cyc", 64'(dones[0]), 64'(beats[7].cyc + 2));

        // Done on an idle block, second pulse merged
        dones.delete();
        n0 = cyc;
        i_sm_render_done = 1'b1;
        step(2);
        i_sm_render_done = 1'b0;
        step(6);
        check("idle_done_count", 64'(dones.size()), 64'd1);
        if (dones.size() == 1)
            check("idle_done_cyc", 64'(dones[0]), 64'(n0 + 2));

        // Reset during beat 2
        beats.delete();
        send_row(6'd3, 6'd4, 4'd5, mk_row(8'h61));
        n0 = 0;
        while (!(o_fb_we && o_fb_addr == 17'd11054) && n0 < 20) begin
            step(1);
            n0++;
        end
        check("beat2_seen", 64'(o_fb_addr), 64'd11054);
        i_fb_ready = 1'b0;
        rst_n = 1'b0;
        step(1);
        check("rst_mid_we",   64'(o_fb_we), 64'd0);
        check("rst_mid_busy", 64'(o_busy),  64'd0);
        rst_n = 1'b1;
        i_fb_ready = 1'b1;
        step(10);
        check("rst_mid_beats", 64'(beats.size()), 64'd2);
        check_row(0, 17'd11052, 8'h61);

        // Out-of-range tile column
        beats.delete();
`ifdef FB_ROW_WRITER_BOUNDS_CHECK_EN
        send_row(6'd40, 6'd0, 4'd0, mk_row(8'h71));
        step(8);
        check("oob_beats", 64'(beats.size()), 64'd0);
        check("oob_err",   64'(o_err_coord),  64'd1);
`else
        send_row(6'd40, 6'd0, 4'd0, mk_row(8'h71));
        send_row(6'd63, 6'd63, 4'd15, mk_row(8'h72));
        wait_beats(8, 20);
        check_row(0, 17'd160,   8'h71);
        check_row(4, 17'd32860, 8'h72);
        check("oob_err", 64'(o_err_coord), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
